teami_hamming_encoder_tx: RTL and testbench

- Serial transmit end of the team's 8-bit Hamming frame link, the counterpart of the serial receive decoder on the same board.
- Accepts a 4-bit nibble through a valid/ready handshake and encodes it into an 8-bit SEC-DED codeword.
- Shifts the codeword out LSB-first on DDATA, with a DSTROBE marker on the first bit.
- Optional single-bit error injection lets the bench and the lab rig exercise the receiver's correct/flag paths.

---
 rtl/teami_link_pkg.sv | 33 +++
 rtl/teami_hamming84_enc.sv | 23 ++
 rtl/teami_hamming_encoder_tx.sv | 154 +++++++++++++++
 tb/tb_teami_hamming_encoder_tx.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/teami_link_pkg.sv
// Shared definitions for the 8-bit Hamming frame link: frame size, FSM
// states, codeword bit positions and the (8,4) SEC-DED encode function.
package teami_link_pkg;

  localparam int FRAME_BITS = 8;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  // Parity bits sit at even positions, data bits at odd positions.
  localparam int P0_POS = 0;
  localparam int D0_POS = 1;
  localparam int P1_POS = 2;
  localparam int D1_POS = 3;
  localparam int P2_POS = 4;
  localparam int D2_POS = 5;
  localparam int P3_POS = 6;
  localparam int D3_POS = 7;

  function automatic logic [FRAME_BITS-1:0] hamming84_encode(input logic [3:0] nibble);
    logic [FRAME_BITS-1:0] cw;
    cw         = '0;
    cw[D0_POS] = nibble[0];
    cw[D1_POS] = nibble[1];
    cw[D2_POS] = nibble[2];
    cw[D3_POS] = nibble[3];
    cw[P0_POS] = nibble[0] ^ nibble[2] ^ nibble[3];
    cw[P1_POS] = nibble[0] ^ nibble[1] ^ nibble[3];
    cw[P2_POS] = nibble[0] ^ nibble[1] ^ nibble[2];
    cw[P3_POS] = nibble[1] ^ nibble[2] ^ nibble[3];
    return cw;
  endfunction

endpackage

// File: rtl/teami_hamming84_enc.sv
// Combinational nibble-to-codeword encoder with optional single-bit
// error injection for exercising the receiver's correction path.
module teami_hamming84_enc
  import teami_link_pkg::*;
(
  input  logic [3:0]            nibble,
  input  logic                  err_en,
  input  logic [2:0]            err_pos,
  output logic [FRAME_BITS-1:0] codeword
);

  logic [FRAME_BITS-1:0] err_mask;

  // Build the clean codeword, then invert the selected bit when injecting.
  always_comb begin
    err_mask = '0;
    if (err_en) begin
      err_mask[err_pos] = 1'b1;
    end
    codeword = hamming84_encode(nibble) ^ err_mask;
  end

endmodule

// File: rtl/teami_hamming_encoder_tx.sv
// Serial transmitter: encodes accepted nibbles, shifts codewords out
// LSB-first with a strobe on bit 0, inserts idle gaps and counts frames.
module teami_hamming_encoder_tx
  import teami_link_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [3:0]       DIN,
  input  logic             DLOAD,
  input  logic             ERR_EN,
  input  logic [2:0]       ERR_POS,
  output logic             DREADY,
  output logic             DDATA,
  output logic             DSTROBE,
  output logic             DBUSY,
  output logic             DDONE,
  output logic [CNT_W-1:0] FRAME_CNT
);

  localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_t                state, state_next;
  logic [2:0]            bit_idx, bit_next;
  logic [3:0]            gap_cnt, gap_next;
  logic [FRAME_BITS-1:0] sr, sr_next;
  logic [FRAME_BITS-1:0] hold, hold_next;
  logic                  hold_full, hold_full_next;
  logic                  ddata_next, strobe_next, ddone_next;
  logic [CNT_W-1:0]      cnt_next;
  logic [FRAME_BITS-1:0] enc_cw;
  logic [FRAME_BITS-1:0] launch_cw;
  logic                  accept, launch, exit_now, hold_load;

  teami_hamming84_enc u_enc (
    .nibble   (DIN),
    .err_en   (ERR_EN),
    .err_pos  (ERR_POS),
    .codeword (enc_cw)
  );

  assign accept = DLOAD & ~hold_full;
  assign DREADY = ~hold_full;
  assign DBUSY  = (state != IDLE);

  // Next-state logic: bit shifting, gap timing, hold management and frame launch.
  always_comb begin
    state_next     = state;
    bit_next       = bit_idx;
    gap_next       = gap_cnt;
    sr_next        = sr;
    hold_next      = hold;
    hold_full_next = hold_full;
    ddata_next     = 1'b0;
    strobe_next    = 1'b0;
    ddone_next     = 1'b0;
    cnt_next       = FRAME_CNT;
    launch         = 1'b0;
    launch_cw      = enc_cw;
    exit_now       = 1'b0;
    hold_load      = accept;

    unique case (state)
      IDLE: begin
        if (accept) begin
          launch    = 1'b1;
          hold_load = 1'b0;
        end
      end
      SHIFT: begin
        if (bit_idx != 3'd7) begin
          ddata_next = sr[0];
          sr_next    = sr >> 1;
          bit_next   = bit_idx + 3'd1;
        end else begin
          ddone_next = 1'b1;
          cnt_next   = FRAME_CNT + CNT_W'(1);
          if (GAP_CYCLES > 0) begin
            state_next = GAP;
            gap_next   = 4'd0;
          end else begin
            exit_now = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          exit_now = 1'b1;
        end else begin
          gap_next = gap_cnt + 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    // A pending hold frame has priority; a nibble arriving on the exit edge
    // goes straight to the shifter so it is never stranded in the hold.
    if (exit_now) begin
      if (hold_full) begin
        launch         = 1'b1;
        launch_cw      = hold;
        hold_full_next = 1'b0;
      end else if (accept) begin
        launch    = 1'b1;
        hold_load = 1'b0;
      end else begin
        state_next = IDLE;
      end
    end

    if (hold_load) begin
      hold_next      = enc_cw;
      hold_full_next = 1'b1;
    end

    if (launch) begin
      state_next  = SHIFT;
      bit_next    = 3'd0;
      sr_next     = launch_cw >> 1;
      ddata_next  = launch_cw[0];
      strobe_next = 1'b1;
    end
  end

  // State and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state     <= IDLE;
      bit_idx   <= 3'd0;
      gap_cnt   <= 4'd0;
      sr        <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      DDATA     <= 1'b0;
      DSTROBE   <= 1'b0;
      DDONE     <= 1'b0;
      FRAME_CNT <= '0;
    end else begin
      state     <= state_next;
      bit_idx   <= bit_next;
      gap_cnt   <= gap_next;
      sr        <= sr_next;
      hold      <= hold_next;
      hold_full <= hold_full_next;
      DDATA     <= ddata_next;
      DSTROBE   <= strobe_next;
      DDONE     <= ddone_next;
      FRAME_CNT <= cnt_next;
    end
  end

endmodule

// File: tb/tb_teami_hamming_encoder_tx.sv
// Directed bench for the Hamming serial transmitter: wire codewords, strobe
// and done timing, hold/back-to-back behaviour, error injection, reset abort
// and frame counter wrap.
module tb_teami_hamming_encoder_tx;

  logic       CLOCK;
  logic       RESET;
  logic [3:0] DIN;
  logic       DLOAD;
  logic       ERR_EN;
  logic [2:0] ERR_POS;
  logic       DREADY;
  logic       DDATA;
  logic       DSTROBE;
  logic       DBUSY;
  logic       DDONE;
  logic [7:0] FRAME_CNT;

  int test_count = 0;
  int fail_count = 0;
  int done_pulses = 0;

  // Hand-computed codewords for nibbles 0..F (bit i of each entry is B[i]).
  logic [7:0] cw_table [16] = '{8'h00, 8'h17, 8'h5C, 8'h4B, 8'h71, 8'h66, 8'h2D, 8'h3A,
                                8'hC5, 8'hD2, 8'h99, 8'h8E, 8'hB4, 8'hA3, 8'hE8, 8'hFF};

  logic [31:0] log_ddata, log_strobe, log_done, log_ready;

  teami_hamming_encoder_tx #(.GAP_CYCLES(2), .CNT_W(8)) dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .DIN       (DIN),
    .DLOAD     (DLOAD),
    .ERR_EN    (ERR_EN),
    .ERR_POS   (ERR_POS),
    .DREADY    (DREADY),
    .DDATA     (DDATA),
    .DSTROBE   (DSTROBE),
    .DBUSY     (DBUSY),
    .DDONE     (DDONE),
    .FRAME_CNT (FRAME_CNT)
  );

  // 10 ns clock.
  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Count every cycle with DDONE high, sampled mid-cycle.
  always @(negedge CLOCK) begin
    if (DDONE) done_pulses = done_pulses + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    test_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  // Present one nibble for exactly one edge, then drop DLOAD.
  task automatic applyStimulus(input logic [3:0] nib, input logic err_en, input logic [2:0] err_pos);
    DIN     = nib;
    ERR_EN  = err_en;
    ERR_POS = err_pos;
    DLOAD   = 1'b1;
    step();
    DLOAD   = 1'b0;
    ERR_EN  = 1'b0;
  endtask

  task automatic logSample(input int c);
    log_ddata[c]  = DDATA;
    log_strobe[c] = DSTROBE;
    log_done[c]   = DDONE;
    log_ready[c]  = DREADY;
  endtask

  // Starting in the B0 cycle, capture 9 cycles (B0..B7 plus the DDONE cycle).
  task automatic captureFrame();
    log_ddata = '0; log_strobe = '0; log_done = '0; log_ready = '0;
    for (int i = 0; i < 9; i++) begin
      logSample(i);
      if (i < 8) step();
    end
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (DBUSY && n < 40) begin
      step();
      n++;
    end
    if (DBUSY) checkOutput(tag, {31'd0, DBUSY}, 32'd0);
  endtask

  task automatic doReset();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
  endtask

  // Independent SEC-DED receiver model used to judge injected errors.
  function automatic void hamming_decode_model(input logic [7:0] r, output logic [3:0] data,
                                               output logic derror, output logic [2:0] syn,
                                               output logic ovr);
    logic [7:0] fixed;
    int pos;
    syn = {r[1] ^ r[3] ^ r[4] ^ r[5], r[1] ^ r[2] ^ r[3] ^ r[7], r[0] ^ r[1] ^ r[5] ^ r[7]};
    ovr = ^r;
    case (syn)
      3'd1:    pos = 0;
      3'd7:    pos = 1;
      3'd2:    pos = 2;
      3'd6:    pos = 3;
      3'd4:    pos = 4;
      3'd5:    pos = 5;
      3'd0:    pos = 6;
      default: pos = 7;
    endcase
    fixed = r;
    if (ovr) fixed[pos] = ~fixed[pos];
    derror = !ovr && (syn != 3'd0);
    data = {fixed[7], fixed[5], fixed[3], fixed[1]};
  endfunction

  initial begin
    logic [3:0] dec_data;
    logic       dec_err, dec_ovr, seen_done, seen_busy;
    logic [2:0] dec_syn;
    int         bad, pulses_before;

    RESET = 1'b1; DIN = 4'hF; DLOAD = 1'b1; ERR_EN = 1'b0; ERR_POS = 3'd0;
    step();
    step();
    RESET = 1'b0;
    DLOAD = 1'b0;

    // Reset state; the DLOAD held during reset must have been ignored.
    checkOutput("rst_dready", {31'd0, DREADY}, 32'd1);
    checkOutput("rst_ddata", {31'd0, DDATA}, 32'd0);
    checkOutput("rst_strobe", {31'd0, DSTROBE}, 32'd0);
    checkOutput("rst_busy", {31'd0, DBUSY}, 32'd0);
    checkOutput("rst_done", {31'd0, DDONE}, 32'd0);
    checkOutput("rst_cnt", {24'd0, FRAME_CNT}, 32'd0);
    step();
    checkOutput("rst_busy2", {31'd0, DBUSY}, 32'd0);

    // Basic frame: 1011 -> 8E, strobe on B0 only, DDONE one cycle after B7.
    applyStimulus(4'b1011, 1'b0, 3'd0);
    captureFrame();
    checkOutput("f1_data", log_ddata, 32'h08E);
    checkOutput("f1_strobe", log_strobe, 32'h001);
    checkOutput("f1_done", log_done, 32'h100);
    checkOutput("f1_cnt", {24'd0, FRAME_CNT}, 32'd1);
    checkOutput("f1_busy_gap", {31'd0, DBUSY}, 32'd1);
    waitIdle("f1_idle");
    checkOutput("idle_dready", {31'd0, DREADY}, 32'd1);

    // Back-to-back 0 then F: second nibble waits in hold through the gap.
    log_ddata = '0; log_strobe = '0; log_done = '0; log_ready = '0;
    applyStimulus(4'h0, 1'b0, 3'd0);
    logSample(0);
    applyStimulus(4'hF, 1'b0, 3'd0);
    for (int c = 1; c < 20; c++) begin
      logSample(c);
      if (c < 19) step();
    end
    checkOutput("b2b_data", log_ddata, 32'h3FC00);
    checkOutput("b2b_strobe", log_strobe, 32'h00401);
    checkOutput("b2b_done", log_done, 32'h40100);
    checkOutput("b2b_ready", log_ready, 32'hFFC01);
    checkOutput("b2b_cnt", {24'd0, FRAME_CNT}, 32'd3);
    waitIdle("b2b_idle");

    // Injected error on a data bit: receiver corrects back to 1011.
    applyStimulus(4'b1011, 1'b1, 3'd3);
    captureFrame();
    checkOutput("inj3_data", log_ddata, 32'h086);
    hamming_decode_model(log_ddata[7:0], dec_data, dec_err, dec_syn, dec_ovr);
    checkOutput("inj3_corr", {28'd0, dec_data}, 32'hB);
    checkOutput("inj3_derr", {31'd0, dec_err}, 32'd0);
    waitIdle("inj3_idle");

    // Injected error on B6: only the overall parity check trips.
    applyStimulus(4'b1011, 1'b1, 3'd6);
    captureFrame();
    checkOutput("inj6_data", log_ddata, 32'h0CE);
    hamming_decode_model(log_ddata[7:0], dec_data, dec_err, dec_syn, dec_ovr);
    checkOutput("inj6_syn", {29'd0, dec_syn}, 32'd0);
    checkOutput("inj6_ovr", {31'd0, dec_ovr}, 32'd1);
    checkOutput("inj6_corr", {28'd0, dec_data}, 32'hB);
    waitIdle("inj6_idle");

    // Reset during bit 4 aborts the frame with no DDONE.
    applyStimulus(4'b1011, 1'b0, 3'd0);
    for (int i = 0; i < 4; i++) step();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    checkOutput("abort_ddata", {31'd0, DDATA}, 32'd0);
    checkOutput("abort_busy", {31'd0, DBUSY}, 32'd0);
    checkOutput("abort_ready", {31'd0, DREADY}, 32'd1);
    checkOutput("abort_cnt", {24'd0, FRAME_CNT}, 32'd0);
    seen_done = DDONE;
    seen_busy = DBUSY;
    for (int i = 0; i < 8; i++) begin
      step();
      seen_done = seen_done | DDONE;
      seen_busy = seen_busy | DBUSY;
    end
    checkOutput("abort_nodone", {31'd0, seen_done}, 32'd0);
    checkOutput("abort_nobusy", {31'd0, seen_busy}, 32'd0);

    // Nibble 5 after the abort goes out clean (B0..B7 = 0,1,1,0,0,1,1,0).
    applyStimulus(4'h5, 1'b0, 3'd0);
    captureFrame();
    checkOutput("post_abort_data", log_ddata, 32'h066);
    checkOutput("post_abort_strobe", log_strobe, 32'h001);
    checkOutput("post_abort_cnt", {24'd0, FRAME_CNT}, 32'd1);
    waitIdle("post_abort_idle");

    // Package encode function against the hand table.
    for (int n = 0; n < 16; n++) begin
      checkOutput($sformatf("pkg_enc_%0h", n),
                  {24'd0, teami_link_pkg::hamming84_encode(4'(n))}, {24'd0, cw_table[n]});
    end

    // 256 frames: every nibble on the wire, counter wraps, one DDONE per frame.
    doReset();
    pulses_before = done_pulses;
    bad = 0;
    for (int f = 0; f < 256; f++) begin
      applyStimulus(4'(f), 1'b0, 3'd0);
      captureFrame();
      if (f < 16) begin
        checkOutput($sformatf("wire_%0h", f), log_ddata, {24'd0, cw_table[f]});
      end else if (log_ddata !== {24'd0, cw_table[f % 16]} || log_strobe !== 32'h001 ||
                   log_done !== 32'h100) begin
        bad++;
      end
      if (f == 254) checkOutput("cnt_255", {24'd0, FRAME_CNT}, 32'd255);
      if (f == 255) checkOutput("cnt_wrap", {24'd0, FRAME_CNT}, 32'd0);
      waitIdle("bulk_idle");
    end
    checkOutput("bulk_frames", bad, 0);
    step();
    checkOutput("bulk_done_pulses", done_pulses - pulses_before, 256);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
